// File: rtl/xrv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// No logic; imported by ifetch_unit and ifetch_fifo.
// Holds the FSM state encoding, the NOP filler word and the sequential PC increment.
package xrv_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO holding {instr, pc} pairs between memory response and decoder.
// Latency: a push is visible at the head the cycle after; flush clears everything at once.
// Backpressure: when full, a push is accepted only together with a pop; otherwise it is an error.
module ifetch_fifo
    import xrv_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_dat,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [WIDTH-1:0]             o_pop_dat,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_pop_dat = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            assert (!(i_push && o_full && !w_do_pop));
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC, in-order imem requests, response buffer, redirect with stale-response drop.
// Latency: response in cycle N -> instr_valid in N+1; IFETCH_MISALIGN_TRAP_EN enables misaligned-redirect trap.
// Backpressure: requests stop when in-flight + buffered reaches FIFO_DEPTH, resuming as the decoder pops.
module ifetch_unit
    import xrv_fetch_pkg::*;
#(
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter logic [AW-1:0] RESET_PC   = '0,
    parameter int            FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_rsp_valid,
    input  logic [DW-1:0] imem_rsp_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          fetch_misalign
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [AW-1:0]    r_pc;
    logic [CW-1:0]    r_outstanding;
    logic [CW-1:0]    r_drop_cnt;
    logic [CW-1:0]    w_out_nxt;
    logic [CW-1:0]    w_drop_nxt;
    logic [AW-1:0]    r_pcq [FIFO_DEPTH];
    logic [PW-1:0]    r_pcq_wr;
    logic [PW-1:0]    r_pcq_rd;
    logic [AW-1:0]    w_redirect_pc;
    logic             w_misalign;
    logic             w_credit_ok;
    logic             w_req_accept;
    logic             w_rsp_keep;
    logic             w_fifo_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CW-1:0]    w_fifo_count;
    logic [DW+AW-1:0] w_fifo_dout;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_redirect_pc = redirect_pc;
    assign w_misalign    = r_misalign;

    // Sticky until the next redirect, which re-evaluates alignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_misalign <= 1'b0;
        else if (redirect_valid) r_misalign <= |redirect_pc[1:0];
    end
`else
    assign w_redirect_pc = redirect_pc & ~AW'(3);
    assign w_misalign    = 1'b0;
`endif

    assign fetch_misalign = w_misalign;
    assign imem_req_addr  = r_pc;

    assign w_credit_ok  = !w_fifo_full &&
                          (({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < (CW+1)'(FIFO_DEPTH));
    assign w_req_accept = imem_req_valid && imem_req_ready;
    assign w_rsp_keep   = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_fifo_pop   = instr_valid && instr_ready && !redirect_valid;
    assign w_out_nxt    = r_outstanding + CW'(w_req_accept) - CW'(imem_rsp_valid);

    // On redirect everything still in flight after this cycle becomes stale.
    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (redirect_valid)
            w_drop_nxt = w_out_nxt;
        else if (imem_rsp_valid && (r_drop_cnt != '0))
            w_drop_nxt = r_drop_cnt - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = FETCH;
            FETCH:   if (redirect_valid && (w_drop_nxt != '0)) w_state_nxt = DRAIN;
            DRAIN:   if (w_drop_nxt == '0) w_state_nxt = FETCH;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = (r_state != IDLE) && w_credit_ok && !redirect_valid && !w_misalign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            r_drop_cnt    <= w_drop_nxt;
            if (redirect_valid) begin
                r_pc     <= w_redirect_pc;
                r_pcq_wr <= '0;
                r_pcq_rd <= '0;
            end else begin
                if (w_req_accept) begin
                    r_pc     <= r_pc + AW'(PC_STEP);
                    r_pcq_wr <= r_pcq_wr + PW'(1);
                end
                if (w_rsp_keep) r_pcq_rd <= r_pcq_rd + PW'(1);
            end
        end
    end

    // PC of each live request; dropped responses never consume an entry.
    always_ff @(posedge clk) begin
        if (w_req_accept) r_pcq[r_pcq_wr] <= r_pc;
    end

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DW + AW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_rsp_keep),
        .i_push_dat ({imem_rsp_data, r_pcq[r_pcq_rd]}),
        .i_pop      (w_fifo_pop),
        .i_flush    (redirect_valid),
        .o_pop_dat  (w_fifo_dout),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count)
    );

    assign instr_valid = !w_fifo_empty && !w_misalign;
    assign instr       = instr_valid ? w_fifo_dout[DW+AW-1:AW] : DW'(NOP_INSTR);
    assign instr_pc    = instr_valid ? w_fifo_dout[AW-1:0] : '0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with an in-order 1-cycle-latency instruction memory model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_misalign;

    logic        mem_hold;
    logic [31:0] mq[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_ins[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifetch_unit #(
        .AW         (32),
        .DW         (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_misalign (fetch_misalign)
    );

    function automatic logic [31:0] mword(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory: responds in order, one cycle after accept, unless held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back(imem_req_addr);
                acc_log.push_back(imem_req_addr);
            end
            if (!mem_hold && mq.size() > 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mword(mq.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
                imem_rsp_data  <= 32'h0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
            pop_pc.push_back(instr_pc);
            pop_ins.push_back(instr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pc_at(input int i);
        return (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] ins_at(input int i);
        return (i < pop_ins.size()) ? pop_ins[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        return (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic wait_pops(input string tag, input int n);
        int cyc = 0;
        while (pop_pc.size() < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(pop_pc.size() >= n), 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        int p;
        int a;
        int k;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        mem_hold       = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_misalign", 32'(fetch_misalign), 32'd0);

        // Test 1: sequential stream from reset
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        rst_n          = 1'b1;
        @(negedge clk);
        check("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
        check("t1_first_req_addr", imem_req_addr, 32'h0);
        check("t1_valid_c1", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("t1_valid_c2", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("t1_valid_c3", 32'(instr_valid), 32'd1);
        check("t1_pc_c3", instr_pc, 32'h0);
        check("t1_instr_c3", instr, 32'h5A5A_0000);
        wait_pops("t1_wait", 4);
        check("t1_pop0", pc_at(0), 32'h0);
        check("t1_pop1", pc_at(1), 32'h4);
        check("t1_pop2", pc_at(2), 32'h8);
        check("t1_pop3", pc_at(3), 32'hC);
        check("t1_ins2", ins_at(2), 32'h5A5A_0008);
        check("t1_acc3", acc_at(3), 32'hC);

        // Test 2: decoder stalled, credit limit of 2
        instr_ready = 1'b0;
        a = acc_log.size();
        do_redirect(32'h40);
        repeat (8) @(negedge clk);
        check("t2_req_count", 32'(acc_log.size() - a), 32'd2);
        check("t2_acc0", acc_at(a), 32'h40);
        check("t2_acc1", acc_at(a + 1), 32'h44);
        check("t2_req_blocked", 32'(imem_req_valid), 32'd0);
        check("t2_head_pc", instr_pc, 32'h40);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("t2_after_pop_pc", instr_pc, 32'h44);
        check("t2_after_pop_req", 32'(imem_req_valid), 32'd1);
        check("t2_after_pop_addr", imem_req_addr, 32'h48);

        // Test 3: two outstanding, redirect drops both
        instr_ready = 1'b1;
        repeat (6) @(negedge clk);
        mem_hold = 1'b1;
        repeat (6) @(negedge clk);
        check("t3_held_count", 32'(mq.size()), 32'd2);
        check("t3_held_req", 32'(imem_req_valid), 32'd0);
        p = pop_pc.size();
        do_redirect(32'h100);
        check("t3_flushed", 32'(instr_valid), 32'd0);
        mem_hold = 1'b0;
        wait_pops("t3_wait", p + 2);
        check("t3_pop0", pc_at(p), 32'h100);
        check("t3_pop1", pc_at(p + 1), 32'h104);
        check("t3_ins0", ins_at(p), 32'h5A5A_0100);

        // Test 4: redirect coincides with response and pop
        k = 0;
        while (!(imem_rsp_valid && instr_valid) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t4_found", 32'(imem_rsp_valid && instr_valid), 32'd1);
        p = pop_pc.size();
        do_redirect(32'h300);
        check("t4_empty_next", 32'(instr_valid), 32'd0);
        wait_pops("t4_wait", p + 2);
        check("t4_pop0", pc_at(p), 32'h300);
        check("t4_pop1", pc_at(p + 1), 32'h304);

        // Test 5: PC wrap
        p = pop_pc.size();
        do_redirect(32'hFFFF_FFFC);
        wait_pops("t5_wait", p + 2);
        check("t5_pop0", pc_at(p), 32'hFFFF_FFFC);
        check("t5_pop1", pc_at(p + 1), 32'h0);
        check("t5_ins1", ins_at(p + 1), 32'h5A5A_0000);

        // Test 6: misaligned redirect
        p = pop_pc.size();
        do_redirect(32'h102);
`ifdef IFETCH_MISALIGN_TRAP_EN
        check("t6_misalign_set", 32'(fetch_misalign), 32'd1);
        a = acc_log.size();
        for (int i = 0; i < 5; i++) begin
            check("t6_no_req", 32'(imem_req_valid), 32'd0);
            @(negedge clk);
        end
        check("t6_no_instr", 32'(instr_valid), 32'd0);
        check("t6_no_accept", 32'(acc_log.size() - a), 32'd0);
`else
        check("t6_misalign_tied", 32'(fetch_misalign), 32'd0);
        wait_pops("t6_wait", p + 1);
        check("t6_forced_align", pc_at(p), 32'h100);
`endif
        p = pop_pc.size();
        do_redirect(32'h200);
        check("t6_misalign_clear", 32'(fetch_misalign), 32'd0);
        wait_pops("t6_resume_wait", p + 1);
        check("t6_resume_pc", pc_at(p), 32'h200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
